// File: rtl/traffic_light_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Parametrised traffic-light controller.
//               RED -> YELLOW1 -> GREEN -> YELLOW2 -> RED, each phase lasting
//               T_x ticks of a TICK_DIV-cycle prescaler. A latched pedestrian
//               request shortens GREEN down to T_GREEN_MIN ticks. A night
//               mode replaces the cycle with blinking yellow.
// Ports       : clk        - system clock
//               res        - asynchronous active-high reset
//               ped_req    - pedestrian button (synchronised)
//               night_mode - night-mode select level (synchronised)
//               led2       - red LED (polarity per LED_ACTIVE_LOW)
//               led1       - yellow LED
//               led0       - green LED
//               out_state  - current state code
//               ped_wait   - pedestrian request pending
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int TICK_DIV       = 50000000,
    parameter int T_RED          = 5,
    parameter int T_YEL          = 1,
    parameter int T_GREEN        = 5,
    parameter int T_GREEN_MIN    = 2,
    parameter int T_BLINK        = 1,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       led2,
    output logic       led1,
    output logic       led0,
    output logic [2:0] out_state,
    output logic       ped_wait
);

    typedef enum logic [2:0] {
        ST_RED       = 3'd0,
        ST_YELLOW1   = 3'd1,
        ST_GREEN     = 3'd2,
        ST_YELLOW2   = 3'd3,
        ST_BLINK_ON  = 3'd4,
        ST_BLINK_OFF = 3'd5
    } state_t;

    // Longest phase decides the dwell counter width.
    localparam int C_T_MAX_A = (T_RED > T_YEL) ? T_RED : T_YEL;
    localparam int C_T_MAX_B = (T_GREEN > T_BLINK) ? T_GREEN : T_BLINK;
    localparam int C_T_MAX   = (C_T_MAX_A > C_T_MAX_B) ? C_T_MAX_A : C_T_MAX_B;

    localparam int C_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int C_DWELL_W = (C_T_MAX > 1) ? $clog2(C_T_MAX) : 1;

    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST     = C_PRESC_W'(TICK_DIV - 1);
    localparam logic [C_DWELL_W-1:0] C_RED_LAST       = C_DWELL_W'(T_RED - 1);
    localparam logic [C_DWELL_W-1:0] C_YEL_LAST       = C_DWELL_W'(T_YEL - 1);
    localparam logic [C_DWELL_W-1:0] C_GREEN_LAST     = C_DWELL_W'(T_GREEN - 1);
    localparam logic [C_DWELL_W-1:0] C_GREEN_MIN_LAST = C_DWELL_W'(T_GREEN_MIN - 1);
    localparam logic [C_DWELL_W-1:0] C_BLINK_LAST     = C_DWELL_W'(T_BLINK - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [C_PRESC_W-1:0]   r_presc;
    logic [C_DWELL_W-1:0]   r_dwell;
    logic [C_DWELL_W-1:0]   w_dur_last;
    logic                   r_ped_pend;
    logic                   w_tick;
    logic                   w_phase_end;
    logic                   w_green_early;
    logic                   w_change;
    logic                   w_day_state;
    logic                   w_red;
    logic                   w_yellow;
    logic                   w_green;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_tick     = (r_presc == C_PRESC_LAST);
        w_dur_last = '0;
        case (r_state)
            ST_RED:                   w_dur_last = C_RED_LAST;
            ST_YELLOW1, ST_YELLOW2:   w_dur_last = C_YEL_LAST;
            ST_GREEN:                 w_dur_last = C_GREEN_LAST;
            ST_BLINK_ON, ST_BLINK_OFF: w_dur_last = C_BLINK_LAST;
            default:                  w_dur_last = '0;
        endcase

        w_phase_end   = w_tick && (r_dwell == w_dur_last);
        // A pending pedestrian may cut GREEN short once the minimum elapsed.
        w_green_early = w_tick && r_ped_pend && (r_dwell >= C_GREEN_MIN_LAST);

        w_next = r_state;
        case (r_state)
            ST_RED: begin
                if (w_phase_end) w_next = night_mode ? ST_BLINK_ON : ST_YELLOW1;
            end
            ST_YELLOW1: begin
                if (w_phase_end) w_next = night_mode ? ST_BLINK_ON : ST_GREEN;
            end
            ST_GREEN: begin
                if (w_phase_end || w_green_early)
                    w_next = night_mode ? ST_BLINK_ON : ST_YELLOW2;
            end
            ST_YELLOW2: begin
                if (w_phase_end) w_next = night_mode ? ST_BLINK_ON : ST_RED;
            end
            ST_BLINK_ON: begin
                if (w_phase_end) w_next = ST_BLINK_OFF;
            end
            ST_BLINK_OFF: begin
                if (w_phase_end) w_next = night_mode ? ST_BLINK_ON : ST_RED;
            end
            default: w_next = ST_RED;  // codes 6/7 recover to RED
        endcase

        // No state loops onto itself, so any difference is a transition.
        w_change    = (w_next != r_state);
        w_day_state = (r_state == ST_RED) || (r_state == ST_YELLOW1) ||
                      (r_state == ST_GREEN) || (r_state == ST_YELLOW2);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= ST_RED;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and dwell counter; both restart on every transition so
    // each phase lasts exactly T_x * TICK_DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_presc <= '0;
            r_dwell <= '0;
        end else if (w_change) begin
            r_presc <= '0;
            r_dwell <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_dwell <= r_dwell + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pedestrian latch: a new press on the RED-entry clock wins over the
    // clear. Blink (and illegal) states hold it at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_ped_pend <= 1'b0;
        end else if (w_day_state) begin
            if (ped_req) begin
                r_ped_pend <= 1'b1;
            end else if (w_change && (w_next == ST_RED)) begin
                r_ped_pend <= 1'b0;
            end
        end else begin
            r_ped_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_red    = (r_state == ST_RED);
        w_yellow = (r_state == ST_YELLOW1) || (r_state == ST_YELLOW2) ||
                   (r_state == ST_BLINK_ON);
        w_green  = (r_state == ST_GREEN);
    end

    generate
        if (LED_ACTIVE_LOW != 0) begin : g_led_active_low
            assign {led2, led1, led0} = ~{w_red, w_yellow, w_green};
        end else begin : g_led_active_high
            assign {led2, led1, led0} = {w_red, w_yellow, w_green};
        end
    endgenerate

    assign out_state = r_state;
    assign ped_wait  = r_ped_pend;

endmodule
`default_nettype wire
